// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI master/slave link between NREQ requesters.
// Optional launch-to-completion watchdog is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_req_arbiter #(
  parameter int NREQ           = 4,
  parameter int DW             = 12,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic              err,
  output logic              busy,
  output logic              spi_newd,
  output logic [DW-1:0]     spi_din,
  input  logic              spi_cs,
  input  logic              spi_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("spi_req_arbiter: unsupported NREQ or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

  state_t            state, state_nx;
  logic [PW-1:0]     ptr, ptr_nx;
  logic [PW-1:0]     owner, owner_nx;
  logic [PW-1:0]     win;
  logic [PW-1:0]     owner_inc;
  logic              done_q;
  logic              done_rise;
  logic              tmo;
  logic [NREQ-1:0]   gnt_nx, ack_nx;
  logic              err_nx, busy_nx, newd_nx;
  logic [DW-1:0]     din_nx;

  assign done_rise = spi_done & ~done_q;
  assign owner_inc = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt, cnt_nx;
  assign tmo = (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  // First requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = PW'((32'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    owner_nx = owner;
    gnt_nx   = gnt;
    ack_nx   = '0;
    err_nx   = 1'b0;
    busy_nx  = busy;
    newd_nx  = spi_newd;
    din_nx   = spi_din;
`ifdef SPI_ARB_TIMEOUT_EN
    cnt_nx   = cnt + 1'b1;
`endif
    case (state)
      IDLE: begin
        busy_nx = 1'b0;
        if ((|req) && spi_cs) begin
          state_nx = LAUNCH;
          owner_nx = win;
          gnt_nx   = NREQ'(1'b1) << win;
          din_nx   = req_data[int'(win)*DW +: DW];
          newd_nx  = 1'b1;
          busy_nx  = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
          cnt_nx   = '0;
`endif
        end
      end
      LAUNCH, WAIT_DONE: begin
        // Completion and abort share one exit; busy stays high through the ack cycle.
        if ((state == WAIT_DONE && done_rise) || tmo) begin
          ack_nx   = gnt;
          err_nx   = ~((state == WAIT_DONE) && done_rise);
          gnt_nx   = '0;
          newd_nx  = 1'b0;
          ptr_nx   = owner_inc;
          state_nx = IDLE;
        end else if (state == LAUNCH && !spi_cs) begin
          newd_nx  = 1'b0;
          state_nx = WAIT_DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      done_q   <= 1'b0;
      gnt      <= '0;
      ack      <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      spi_newd <= 1'b0;
      spi_din  <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt      <= '0;
`endif
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      owner    <= owner_nx;
      done_q   <= spi_done;
      gnt      <= gnt_nx;
      ack      <= ack_nx;
      err      <= err_nx;
      busy     <= busy_nx;
      spi_newd <= newd_nx;
      spi_din  <= din_nx;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt      <= cnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed testbench for spi_req_arbiter; spi_cs/spi_done are driven by hand
// to mimic the attached SPI master and slave.
module tb_spi_req_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [47:0] req_data;
  logic [3:0]  gnt, ack;
  logic        err, busy, spi_newd;
  logic [11:0] spi_din;
  logic        spi_cs, spi_done;

  int total;
  int bad;

  spi_req_arbiter #(
    .NREQ(4),
    .DW(12),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .gnt(gnt),
    .ack(ack),
    .err(err),
    .busy(busy),
    .spi_newd(spi_newd),
    .spi_din(spi_din),
    .spi_cs(spi_cs),
    .spi_done(spi_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    spi_cs   = 1'b1;
    spi_done = 1'b0;
    req      = '0;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
  endtask

  // One full transfer for requester idx; req_after is applied in the ack cycle.
  task automatic serve(input int idx, input logic [11:0] data, input logic [3:0] req_after);
    logic [3:0] oh;
    int n;
    oh = 4'b0001 << idx;
    n  = 0;
    while (spi_newd !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (spi_newd !== 1'b1) begin bad++; $display("FAIL launch_wait: newd=%b required 1", spi_newd); end
    total++;
    if (gnt !== oh) begin bad++; $display("FAIL grant_%0d: gnt=%b required %b", idx, gnt, oh); end
    total++;
    if (spi_din !== data) begin bad++; $display("FAIL din_%0d: din=%h required %h", idx, spi_din, data); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_launch: busy=%b required 1", busy); end
    spi_cs = 1'b0;
    tick();
    total++;
    if (spi_newd !== 1'b0 || gnt !== oh) begin
      bad++; $display("FAIL newd_drop: newd=%b gnt=%b required 0 %b", spi_newd, gnt, oh);
    end
    tick();
    tick();
    total++;
    if (ack !== 4'b0000) begin bad++; $display("FAIL early_ack: ack=%b required 0000", ack); end
    spi_done = 1'b1;
    spi_cs   = 1'b1;
    tick();
    total++;
    if (ack !== oh || err !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b1) begin
      bad++; $display("FAIL ack_%0d: ack=%b err=%b gnt=%b busy=%b required %b 0 0000 1",
                      idx, ack, err, gnt, busy, oh);
    end
    req = req_after;
    tick();
    total++;
    if (ack !== 4'b0000) begin bad++; $display("FAIL ack_pulse: ack=%b required 0000", ack); end
    spi_done = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    spi_cs   = 1'b1;
    spi_done = 1'b0;
    tick();
    tick();
    total++;
    if (gnt !== 4'b0 || ack !== 4'b0 || err !== 1'b0 || busy !== 1'b0 ||
        spi_newd !== 1'b0 || spi_din !== 12'h000) begin
      bad++; $display("FAIL reset: gnt=%b ack=%b err=%b busy=%b newd=%b din=%h required all zero",
                      gnt, ack, err, busy, spi_newd, spi_din);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    req_data[11:0] = 12'hA5C;
    req = 4'b0001;
    tick();
    total++;
    if (spi_newd !== 1'b1) begin bad++; $display("FAIL launch_latency: newd=%b required 1", spi_newd); end
    serve(0, 12'hA5C, 4'b0000);
    tick();
    total++;
    if (busy !== 1'b0 || spi_din !== 12'hA5C) begin
      bad++; $display("FAIL idle_hold: busy=%b din=%h required 0 a5c", busy, spi_din);
    end
  endtask

  task automatic test_pair();
    do_reset();
    req_data[23:12] = 12'h123;
    req_data[35:24] = 12'h456;
    req = 4'b0110;
    serve(1, 12'h123, 4'b0100);
    serve(2, 12'h456, 4'b0000);
  endtask

  task automatic test_round_robin();
    logic [11:0] d [4];
    d[0] = 12'h111; d[1] = 12'h2A2; d[2] = 12'h3B3; d[3] = 12'hFC4;
    do_reset();
    req_data = {d[3], d[2], d[1], d[0]};
    req = 4'b1111;
    for (int i = 0; i < 8; i++)
      serve(i % 4, d[i % 4], (i == 7) ? 4'b0000 : 4'b1111);
  endtask

  task automatic test_ignore_done();
    do_reset();
    req_data[11:0] = 12'hABC;
    req = 4'b0001;
    tick();
    spi_done = 1'b1;
    tick();
    total++;
    if (ack !== 4'b0000 || spi_newd !== 1'b1) begin
      bad++; $display("FAIL done_in_launch: ack=%b newd=%b required 0000 1", ack, spi_newd);
    end
    spi_cs = 1'b0;
    tick();
    tick();
    total++;
    if (ack !== 4'b0000 || spi_newd !== 1'b0) begin
      bad++; $display("FAIL done_level: ack=%b newd=%b required 0000 0", ack, spi_newd);
    end
    spi_done = 1'b0;
    tick();
    spi_done = 1'b1;
    spi_cs   = 1'b1;
    tick();
    total++;
    if (ack !== 4'b0001) begin bad++; $display("FAIL done_rerise: ack=%b required 0001", ack); end
    req = 4'b0000;
    tick();
    spi_done = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_data[23:12] = 12'h321;
    req = 4'b0010;
    tick();
    spi_cs = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (gnt !== 4'b0 || busy !== 1'b0 || spi_newd !== 1'b0 || ack !== 4'b0 || spi_din !== 12'h000) begin
      bad++; $display("FAIL reset_mid: gnt=%b busy=%b newd=%b ack=%b din=%h required 0 0 0 0 000",
                      gnt, busy, spi_newd, ack, spi_din);
    end
    tick();
    tick();
    tick();
    total++;
    if (spi_newd !== 1'b0 || busy !== 1'b0 || ack !== 4'b0) begin
      bad++; $display("FAIL reset_cs_stall: newd=%b busy=%b ack=%b required 0 0 0000", spi_newd, busy, ack);
    end
    spi_cs = 1'b1;
    tick();
    total++;
    if (spi_newd !== 1'b1 || gnt !== 4'b0010) begin
      bad++; $display("FAIL reset_relaunch: newd=%b gnt=%b required 1 0010", spi_newd, gnt);
    end
    serve(1, 12'h321, 4'b0000);
  endtask

  task automatic test_cs_stall();
    req_data[47:36] = 12'h9F0;
    spi_cs = 1'b0;
    req = 4'b1000;
    tick();
    tick();
    tick();
    total++;
    if (spi_newd !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0) begin
      bad++; $display("FAIL cs_stall: newd=%b gnt=%b busy=%b required 0 0000 0", spi_newd, gnt, busy);
    end
    spi_cs = 1'b1;
    tick();
    total++;
    if (spi_newd !== 1'b1 || gnt !== 4'b1000) begin
      bad++; $display("FAIL cs_release: newd=%b gnt=%b required 1 1000", spi_newd, gnt);
    end
    serve(3, 12'h9F0, 4'b0000);
  endtask

  task automatic test_timeout();
    logic early;
    do_reset();
    req = 4'b0001;
    tick();
    spi_cs = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    early = 1'b0;
    for (int i = 0; i < 63; i++) begin
      tick();
      if (ack !== 4'b0000 || err !== 1'b0) early = 1'b1;
    end
    total++;
    if (early) begin bad++; $display("FAIL timeout_early: ack/err seen before 64 cycles, required none"); end
    tick();
    total++;
    if (ack !== 4'b0001 || err !== 1'b1 || gnt !== 4'b0000 || spi_newd !== 1'b0) begin
      bad++; $display("FAIL timeout_abort: ack=%b err=%b gnt=%b newd=%b required 0001 1 0000 0",
                      ack, err, gnt, spi_newd);
    end
    req = 4'b0000;
    tick();
    total++;
    if (ack !== 4'b0000 || err !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL timeout_after: ack=%b err=%b busy=%b required 0000 0 0", ack, err, busy);
    end
    spi_cs = 1'b1;
`else
    early = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy !== 1'b1 || err !== 1'b0 || ack !== 4'b0000) early = 1'b1;
    end
    total++;
    if (early) begin bad++; $display("FAIL no_watchdog: busy dropped or err/ack seen, required busy=1 err=0"); end
    do_reset();
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_pair();
    test_round_robin();
    test_ignore_done();
    test_reset_mid();
    test_cs_stall();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
